// File: rtl/cpu_control_fsm.sv
// Multicycle control sequencer for the 16-bit CPU: FETCH/DECODE/EXEC/MEM/WB sequencing,
// memory handshake with timeout, and ALU/PC/IR/register-file control decode.
module cpu_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        run,
    input  logic [15:0] instr,
    input  logic        flag_z,
    input  logic        flag_n,
    input  logic        mem_ready,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        mem_sel,
    output logic        IRload,
    output logic        PCwrite,
    output logic        pc_src,
    output logic [1:0]  ALUop,
    output logic        ALUsrcB,
    output logic        FlagWrite,
    output logic        RFwrite,
    output logic [3:0]  regA,
    output logic [3:0]  regB,
    output logic [3:0]  regW,
    output logic        wb_sel,
    output logic        halted,
    output logic        error
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_ERR
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_SUB   = 4'h3;
    localparam logic [3:0] OP_NAND  = 4'h4;
    localparam logic [3:0] OP_MVI   = 4'h5;
    localparam logic [3:0] OP_BZ    = 4'h6;
    localparam logic [3:0] OP_BNZ   = 4'h7;
    localparam logic [3:0] OP_BPZ   = 4'h8;
    localparam logic [3:0] OP_HALT  = 4'hF;

    // Last counter value on which an unanswered request is still allowed to wait.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [TO_W-1:0] cnt_q, cnt_d;
    logic            error_q, error_d;

    logic [3:0] opcode;
    logic [3:0] rx_idx;
    logic [3:0] ry_idx;
    logic       req;
    logic       timeout;
    logic       br_taken;
    logic       unused_instr_bits;

    assign opcode            = instr[15:12];
    assign rx_idx            = {1'b0, instr[10:8]};
    assign ry_idx            = {1'b0, instr[6:4]};
    assign unused_instr_bits = ^{instr[11], instr[7], instr[3:0]};

    // run is only honoured before the fetch request goes out; once issued it stays up.
    always_comb begin
        req = 1'b0;
        if (state_q == S_FETCH) begin
            req = run || (cnt_q != '0);
        end else if (state_q == S_MEM) begin
            req = 1'b1;
        end
        timeout = req && !mem_ready && (cnt_q == TO_LAST);
    end

    always_comb begin
        unique case (opcode)
            OP_BZ:   br_taken = flag_z;
            OP_BNZ:  br_taken = !flag_z;
            OP_BPZ:  br_taken = !flag_n;
            default: br_taken = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        error_d = error_q;
        unique case (state_q)
            S_IDLE: if (run) state_d = S_FETCH;
            S_FETCH, S_MEM: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else if (mem_ready) begin
                    if (state_q == S_FETCH)      state_d = S_DECODE;
                    else if (opcode == OP_LOAD)  state_d = S_WB;
                    else                         state_d = S_FETCH;
                end else if (timeout) begin
                    state_d = S_ERR;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + TO_W'(1);
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                unique case (opcode)
                    OP_LOAD, OP_STORE:               state_d = S_MEM;
                    OP_ADD, OP_SUB, OP_NAND, OP_MVI: state_d = S_WB;
                    OP_HALT:                         state_d = S_HALT;
                    default:                         state_d = S_FETCH;
                endcase
            end
            S_WB:    state_d = S_FETCH;
            default: state_d = state_q;
        endcase
        if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        mem_sel   = 1'b0;
        IRload    = 1'b0;
        PCwrite   = 1'b0;
        pc_src    = 1'b0;
        ALUop     = 2'b00;
        ALUsrcB   = 1'b0;
        FlagWrite = 1'b0;
        RFwrite   = 1'b0;
        regA      = 4'd0;
        regB      = 4'd0;
        regW      = 4'd0;
        wb_sel    = 1'b0;
        halted    = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_rd  = req;
                IRload  = req && mem_ready;
                PCwrite = req && mem_ready;
            end
            S_DECODE: begin
                regA = rx_idx;
                regB = ry_idx;
            end
            S_EXEC: begin
                regA = rx_idx;
                regB = ry_idx;
                unique case (opcode)
                    OP_ADD:  begin ALUop = 2'b00; FlagWrite = 1'b1; end
                    OP_SUB:  begin ALUop = 2'b01; FlagWrite = 1'b1; end
                    OP_NAND: begin ALUop = 2'b10; FlagWrite = 1'b1; end
                    OP_MVI:  begin ALUop = 2'b11; ALUsrcB = 1'b1; end
                    default: begin PCwrite = br_taken; pc_src = br_taken; end
                endcase
            end
            S_MEM: begin
                regA    = rx_idx;
                regB    = ry_idx;
                mem_sel = 1'b1;
                mem_rd  = (opcode == OP_LOAD);
                mem_wr  = (opcode != OP_LOAD);
            end
            S_WB: begin
                regA    = rx_idx;
                regB    = ry_idx;
                regW    = rx_idx;
                RFwrite = 1'b1;
                wb_sel  = (opcode == OP_LOAD);
            end
            S_HALT:  halted = 1'b1;
            default: ;
        endcase
    end

    assign error = error_q;

endmodule

// File: tb/tb_cpu_control_fsm.sv
// Directed and randomised checks of the CPU control sequencer's per-cycle control outputs.
module tb_cpu_control_fsm;

    logic        CLK;
    logic        reset;
    logic        run;
    logic [15:0] instr;
    logic        flag_z;
    logic        flag_n;
    logic        mem_ready;
    logic        mem_rd, mem_wr, mem_sel, IRload, PCwrite, pc_src;
    logic [1:0]  ALUop;
    logic        ALUsrcB, FlagWrite, RFwrite;
    logic [3:0]  regA, regB, regW;
    logic        wb_sel, halted, error;

    int n_cmp = 0;
    int n_bad = 0;

    cpu_control_fsm #(.MEM_TIMEOUT(16), .TO_W(5)) dut (
        .CLK(CLK), .reset(reset), .run(run), .instr(instr),
        .flag_z(flag_z), .flag_n(flag_n), .mem_ready(mem_ready),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_sel(mem_sel),
        .IRload(IRload), .PCwrite(PCwrite), .pc_src(pc_src),
        .ALUop(ALUop), .ALUsrcB(ALUsrcB), .FlagWrite(FlagWrite),
        .RFwrite(RFwrite), .regA(regA), .regB(regB), .regW(regW),
        .wb_sel(wb_sel), .halted(halted), .error(error)
    );

    // {mem_rd, mem_wr, mem_sel, IRload, PCwrite, pc_src, ALUop[1:0], ALUsrcB, FlagWrite, RFwrite, wb_sel, halted, error}
    logic [13:0] ctl;
    logic [11:0] regs;
    assign ctl  = {mem_rd, mem_wr, mem_sel, IRload, PCwrite, pc_src, ALUop,
                   ALUsrcB, FlagWrite, RFwrite, wb_sel, halted, error};
    assign regs = {regA, regB, regW};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    function automatic logic [15:0] rand_instr();
        logic [3:0]  op;
        logic [11:0] rest;
        op   = 4'($urandom_range(0, 14));
        rest = 12'($urandom);
        return {op, rest};
    endfunction

    function automatic logic is_writer(input logic [3:0] op);
        return op inside {4'h0, 4'h2, 4'h3, 4'h4, 4'h5};
    endfunction

    logic ld;
    logic prev_rf;

    initial begin
        reset = 1'b1; run = 1'b0; instr = 16'h0000;
        flag_z = 1'b0; flag_n = 1'b0; mem_ready = 1'b0;
        tick(); tick(); settle();
        check("rst_ctl", 16'(ctl), 16'h0000);
        check("rst_regs", 16'(regs), 16'h0000);
        $display("txn reset -> IDLE");

        // run dropped before the fetch request is issued returns to IDLE
        reset = 1'b0; run = 1'b1; settle();
        check("idle_run", 16'(ctl), 16'h0000);
        tick(); run = 1'b0; mem_ready = 1'b1; settle();
        check("fetch_runlow", 16'(ctl), 16'h0000);
        tick(); run = 1'b1; mem_ready = 1'b0; settle();
        check("back_idle", 16'(ctl), 16'h0000);
        tick(); settle();
        check("fetch_req", 16'(ctl), 16'h2000);
        $display("txn run-low abort in FETCH");

        // ADD r1,r2
        instr = 16'h2120; mem_ready = 1'b1; settle();
        check("add_fetch", 16'(ctl), 16'h2600);
        tick(); settle();
        check("add_dec_ctl", 16'(ctl), 16'h0000);
        check("add_dec_regs", 16'(regs), 16'h0120);
        tick(); settle();
        check("add_exec", 16'(ctl), 16'h0010);
        check("add_exec_regs", 16'(regs), 16'h0120);
        tick(); settle();
        check("add_wb", 16'(ctl), 16'h0008);
        check("add_wb_regs", 16'(regs), 16'h0121);
        $display("txn ADD r1,r2 instr=0x2120");

        // LOAD r3,[r4] with mem_ready held off for two MEM cycles
        tick(); instr = 16'h0340; mem_ready = 1'b1; settle();
        check("ld_fetch", 16'(ctl), 16'h2600);
        tick(); mem_ready = 1'b0; settle();
        check("ld_dec_regs", 16'(regs), 16'h0340);
        tick(); settle();
        check("ld_exec", 16'(ctl), 16'h0000);
        tick(); settle();
        check("ld_mem1", 16'(ctl), 16'h2800);
        tick(); settle();
        check("ld_mem2", 16'(ctl), 16'h2800);
        tick(); mem_ready = 1'b1; settle();
        check("ld_mem3", 16'(ctl), 16'h2800);
        tick(); mem_ready = 1'b0; settle();
        check("ld_wb", 16'(ctl), 16'h000C);
        check("ld_wb_regs", 16'(regs), 16'h0343);
        $display("txn LOAD r3,[r4] instr=0x0340 latency 3");

        // BZ +5 taken, then not taken
        tick(); instr = 16'h6005; mem_ready = 1'b1; flag_z = 1'b1; settle();
        check("bz_fetch", 16'(ctl), 16'h2600);
        tick(); settle();
        check("bz_dec", 16'(ctl), 16'h0000);
        tick(); settle();
        check("bz_taken", 16'(ctl), 16'h0300);
        tick(); flag_z = 1'b0; settle();
        check("bz_refetch", 16'(ctl), 16'h2600);
        tick(); settle();
        tick(); settle();
        check("bz_not_taken", 16'(ctl), 16'h0000);
        $display("txn BZ +5 instr=0x6005 taken/not-taken");

        // BPZ with N clear is taken
        tick(); instr = 16'h8005; flag_n = 1'b0; settle();
        check("bpz_fetch", 16'(ctl), 16'h2600);
        tick(); settle();
        tick(); settle();
        check("bpz_taken", 16'(ctl), 16'h0300);
        $display("txn BPZ +5 instr=0x8005");

        // MVI r3 selects PASS-B with the immediate and leaves flags alone
        tick(); instr = 16'h5312; settle();
        check("mvi_fetch", 16'(ctl), 16'h2600);
        tick(); settle();
        tick(); settle();
        check("mvi_exec", 16'(ctl), 16'h00E0);
        tick(); mem_ready = 1'b0; settle();
        check("mvi_wb", 16'(ctl), 16'h0008);
        check("mvi_wb_regs", 16'(regs), 16'h0313);
        $display("txn MVI r3 instr=0x5312");

        // Fetch never acknowledged: 16 request cycles then ERR
        tick(); settle();
        for (int i = 0; i < 16; i++) begin
            if (i != 0) begin
                tick(); settle();
            end
            check($sformatf("to_wait%0d", i), 16'(ctl), 16'h2000);
        end
        tick(); settle();
        check("to_err", 16'(ctl), 16'h0001);
        check("to_err_regs", 16'(regs), 16'h0000);
        mem_ready = 1'b1; run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); settle();
            check($sformatf("err_hold%0d", i), 16'(ctl), 16'h0001);
        end
        $display("txn fetch timeout -> ERR");

        // mem_ready on the last allowed cycle is accepted with no error
        reset = 1'b1; tick(); reset = 1'b0; mem_ready = 1'b0; instr = 16'h2340; settle();
        check("rst2_ctl", 16'(ctl), 16'h0000);
        tick(); settle();
        for (int i = 0; i < 15; i++) tick();
        mem_ready = 1'b1; settle();
        check("edge_ready", 16'(ctl), 16'h2600);
        tick(); mem_ready = 1'b0; settle();
        check("edge_dec", 16'(ctl), 16'h0000);
        check("edge_dec_regs", 16'(regs), 16'h0340);
        tick(); settle();
        tick(); settle();
        $display("txn fetch acked on last cycle before timeout");

        // STORE interrupted by reset while in MEM
        tick(); instr = 16'h1560; mem_ready = 1'b1; settle();
        check("st_fetch", 16'(ctl), 16'h2600);
        tick(); mem_ready = 1'b0; settle();
        check("st_dec_regs", 16'(regs), 16'h0560);
        tick(); settle();
        tick(); settle();
        check("st_mem", 16'(ctl), 16'h1800);
        reset = 1'b1;
        tick(); settle();
        check("st_reset", 16'(ctl), 16'h0000);
        $display("txn STORE instr=0x1560 reset mid-MEM");

        // HALT is absorbing while run stays high
        reset = 1'b0; run = 1'b1; instr = 16'hF000; mem_ready = 1'b1;
        tick(); settle();
        check("halt_fetch", 16'(ctl), 16'h2600);
        tick(); settle();
        tick(); settle();
        check("halt_exec", 16'(ctl), 16'h0000);
        for (int i = 0; i < 4; i++) begin
            tick(); settle();
            check($sformatf("halt_hold%0d", i), 16'(ctl), 16'h0002);
        end
        $display("txn HALT instr=0xF000");

        // Random instruction stream against a random-latency memory
        reset = 1'b1; tick(); reset = 1'b0; run = 1'b1;
        ld = 1'b0; prev_rf = 1'b0; instr = rand_instr();
        for (int i = 0; i < 400; i++) begin
            tick();
            if (ld) instr = rand_instr();
            mem_ready = ($urandom_range(0, 2) != 0);
            flag_z = 1'($urandom_range(0, 1));
            flag_n = 1'($urandom_range(0, 1));
            settle();
            check("rnd_onehot", 16'(mem_rd & mem_wr), 16'h0000);
            if (RFwrite) begin
                check("rnd_regw", 16'(regW), 16'({1'b0, instr[10:8]}));
                check("rnd_rf_single", 16'(prev_rf), 16'h0000);
                check("rnd_rf_op", 16'(is_writer(instr[15:12])), 16'h0001);
            end
            if (IRload) $display("txn random fetch cycle %0d", i);
            ld = IRload;
            prev_rf = RFwrite;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
